// File: rtl/envelope_pwm_dac.sv
// Linear attack/sustain/release envelope applied to an offset-binary
// sample, driven out as a parallel level and as a 256-clock PWM.
module envelope_pwm_dac #(
   parameter int ENV_DIV      = 50000,
   parameter int ATTACK_STEP  = 8,
   parameter int RELEASE_STEP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sample_in,
   input  logic       key_on,
   output logic [7:0] level_out,
   output logic       pwm_out,
   output logic [7:0] env_out,
   output logic       active
);

   localparam int PW = $clog2(ENV_DIV);
   localparam logic [PW-1:0] PMAX = PW'(ENV_DIV - 1);
   localparam logic [8:0] AS9 = 9'(ATTACK_STEP);
   localparam logic [7:0] RS8 = 8'(RELEASE_STEP);

   typedef enum logic [1:0] {
      IDLE,
      ATTACK,
      SUSTAIN,
      RELEASE
   } state_t;

   state_t state, state_n;

   logic [7:0]    env, env_n;
   logic [PW-1:0] pre;
   logic          tick;
   logic [8:0]    att_sum;
   logic [7:0]    att_env;
   logic [7:0]    rel_env;

   logic signed [8:0]  c;
   logic signed [17:0] c18;
   logic signed [17:0] e18;
   logic signed [17:0] p;
   logic signed [17:0] s;
   logic [7:0]         result;

   logic [7:0] pcnt;
   logic [7:0] duty;

   assign tick = (pre == PMAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // Saturating step arithmetic for both ramp directions
   assign att_sum = {1'b0, env} + AS9;
   assign att_env = att_sum[8] ? 8'hFF : att_sum[7:0];
   assign rel_env = (env > RS8) ? env - RS8 : 8'h00;

   always_comb begin
      state_n = state;
      env_n   = env;
      unique case (state)
         IDLE: begin
            env_n = 8'h00;
            if (key_on) state_n = ATTACK;
         end
         ATTACK: begin
            if (!key_on) begin
               state_n = RELEASE;
            end else if (tick) begin
               env_n = att_env;
               if (att_env == 8'hFF) state_n = SUSTAIN;
            end
         end
         SUSTAIN: begin
            env_n = 8'hFF;
            if (!key_on) state_n = RELEASE;
         end
         RELEASE: begin
            if (key_on) begin
               state_n = ATTACK;
            end else if (tick) begin
               env_n = rel_env;
               if (rel_env == 8'h00) state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            env_n   = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         env    <= 8'h00;
         active <= 1'b0;
      end else begin
         state  <= state_n;
         env    <= env_n;
         active <= (state_n != IDLE);
      end
   end

   assign env_out = env;

   // Signed scaling around midscale; floor shift keeps result in 0..254
   assign c      = $signed({1'b0, sample_in}) - 9'sd128;
   assign c18    = 18'(c);
   assign e18    = $signed({10'b0, env});
   assign p      = c18 * e18;
   assign s      = p >>> 8;
   assign result = 8'(s + 18'sd128);

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt      <= 8'h00;
         duty      <= 8'd128;
         level_out <= 8'd128;
         pwm_out   <= 1'b0;
      end else begin
         pcnt    <= pcnt + 8'd1;
         pwm_out <= (pcnt < duty);
         if (pcnt == 8'hFF) begin
            duty      <= result;
            level_out <= result;
         end
      end
   end

endmodule

// File: tb/tb_envelope_pwm_dac.sv
// Randomized and directed checks of envelope_pwm_dac against an
// arithmetic reference model of the envelope, scaling and PWM.
module tb_envelope_pwm_dac;

   localparam int ENV_DIV = 4;
   localparam int AS      = 64;
   localparam int RS      = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sample_in;
   logic       key_on;
   logic [7:0] level_out;
   logic       pwm_out;
   logic [7:0] env_out;
   logic       active;

   int checks = 0;
   int errors = 0;

   int m_ph, m_env, m_pre, m_pcnt, m_duty, m_lvl, m_pwm, m_act;

   envelope_pwm_dac #(
      .ENV_DIV(ENV_DIV),
      .ATTACK_STEP(AS),
      .RELEASE_STEP(RS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sample_in(sample_in),
      .key_on(key_on),
      .level_out(level_out),
      .pwm_out(pwm_out),
      .env_out(env_out),
      .active(active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int scale(input int smp, input int e);
      int prod;
      prod = (smp - 128) * e;
      if (prod >= 0) return 128 + prod / 256;
      return 128 - ((-prod + 255) / 256);
   endfunction

   // ph: 0 idle, 1 attack, 2 sustain, 3 release
   task automatic model_update();
      int tick, res, ph, e;
      if (rst) begin
         m_ph = 0; m_env = 0; m_pre = 0; m_pcnt = 0;
         m_duty = 128; m_lvl = 128; m_pwm = 0; m_act = 0;
         return;
      end
      tick = (m_pre == ENV_DIV - 1);
      res  = scale(int'(sample_in), m_env);
      ph = m_ph;
      e  = m_env;
      case (m_ph)
         0: begin
            e = 0;
            if (key_on) ph = 1;
         end
         1: begin
            if (!key_on) ph = 3;
            else if (tick) begin
               e = (m_env + AS > 255) ? 255 : m_env + AS;
               if (e == 255) ph = 2;
            end
         end
         2: begin
            e = 255;
            if (!key_on) ph = 3;
         end
         default: begin
            if (key_on) ph = 1;
            else if (tick) begin
               e = (m_env - RS < 0) ? 0 : m_env - RS;
               if (e == 0) ph = 0;
            end
         end
      endcase
      m_pwm = (m_pcnt < m_duty) ? 1 : 0;
      if (m_pcnt == 255) begin
         m_duty = res;
         m_lvl  = res;
      end
      m_pcnt = (m_pcnt + 1) % 256;
      m_pre  = (m_pre + 1) % ENV_DIV;
      m_ph   = ph;
      m_env  = e;
      m_act  = (ph != 0) ? 1 : 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("level", int'(level_out), m_lvl);
      chk("env", int'(env_out), m_env);
      chk("active", int'(active), m_act);
      chk("pwm", int'(pwm_out), m_pwm);
   endtask

   task automatic wait_env(input int target, input int budget,
                           output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (int'(env_out) == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic next_env(input int budget, output int val);
      int last;
      last = int'(env_out);
      val  = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (int'(env_out) != last) begin
            val = int'(env_out);
            break;
         end
      end
   endtask

   task automatic pwm_count(output int hi);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         hi += int'(pwm_out);
      end
   endtask

   initial begin
      int hi, v;
      bit ok;
      int exp_att[4];
      int exp_rel[3];
      exp_att = '{64, 128, 192, 255};
      exp_rel = '{155, 55, 0};

      rst = 1'b1;
      key_on = 1'b0;
      sample_in = 8'd200;
      step();
      step();
      chk("rst_level", int'(level_out), 128);
      chk("rst_env", int'(env_out), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_pwm", int'(pwm_out), 0);
      rst = 1'b0;
      repeat (1000) step();
      chk("idle_level", int'(level_out), 128);
      pwm_count(hi);
      chk("idle_pwm_hi", hi, 128);

      sample_in = 8'd255;
      key_on = 1'b1;
      for (int k = 0; k < 4; k++) begin
         next_env(20, v);
         chk("attack_env", v, exp_att[k]);
      end
      repeat (600) step();
      chk("sustain_active", int'(active), 1);
      chk("sustain_level", int'(level_out), 254);
      pwm_count(hi);
      chk("sustain_pwm_hi", hi, 254);

      sample_in = 8'd0;
      key_on = 1'b0;
      for (int k = 0; k < 3; k++) begin
         next_env(20, v);
         chk("release_env", v, exp_rel[k]);
      end
      chk("release_idle", int'(active), 0);
      repeat (300) step();
      chk("release_level", int'(level_out), 128);

      key_on = 1'b1;
      wait_env(255, 100, ok);
      chk("retrig_reach_sus", int'(ok), 1);
      key_on = 1'b0;
      wait_env(155, 50, ok);
      chk("retrig_reach_155", int'(ok), 1);
      key_on = 1'b1;
      next_env(20, v);
      chk("retrig_env", v, 155 + AS);

      for (int i = 0; i < 8 && m_pre != ENV_DIV - 1; i++) step();
      chk("tickfall_pre", m_pre, ENV_DIV - 1);
      key_on = 1'b0;
      step();
      chk("tickfall_env", int'(env_out), 155 + AS);
      chk("tickfall_active", int'(active), 1);
      next_env(20, v);
      chk("tickfall_release", v, 155 + AS - RS);

      sample_in = 8'd255;
      key_on = 1'b1;
      wait_env(255, 100, ok);
      chk("rst_sus_reach", int'(ok), 1);
      for (int i = 0; i < 300 && m_pcnt != 100; i++) step();
      chk("rst_sus_pcnt", int'(dut.pcnt), 100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_level", int'(level_out), 128);
      chk("midrst_env", int'(env_out), 0);
      chk("midrst_active", int'(active), 0);
      chk("midrst_pwm", int'(pwm_out), 0);
      chk("midrst_pcnt", int'(dut.pcnt), 0);
      step();
      chk("midrst_pcnt_next", int'(dut.pcnt), 1);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) key_on = ~key_on;
         sample_in = 8'($urandom_range(0, 255));
         rst = ($urandom_range(0, 1999) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/envelope_pwm_dac.md
# envelope_pwm_dac

Output stage that consumes the 8-bit offset-binary wavetable sample from `rom_sample` and the key-held indication from `codeword_processor`. It applies a linear attack/sustain/release amplitude envelope so that notes start and stop without clicks. It then drives the result both as an 8-bit parallel level for the existing R-2R output pins and as a single-pin 8-bit PWM audio signal.

## Interface
- `ENV_DIV`, 50000: clock cycles per envelope step tick (≥2).
- `ATTACK_STEP`, 8: envelope increment per tick during attack (1..255).
- `RELEASE_STEP`, 2: envelope decrement per tick during release (1..255).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  8  offset-binary sample (128 = silence), sampled at PWM period boundary.
- `key_on`  in  1  high while any note key is held (`teclas != 0` upstream); synchronous to `clk`.
- `level_out`  out  8  enveloped sample, offset-binary, for parallel DAC pins.
- `pwm_out`  out  1  PWM of `level_out`, 256-clock period.
- `env_out`  out  8  current envelope value (debug/LED).
- `active`  out  1  high when the state machine is not IDLE.

## Operation
- Prescaler: free-running counter 0..ENV_DIV-1. `tick` is asserted for one cycle when the counter is at ENV_DIV-1, then the counter wraps to 0.
- Envelope FSM states: IDLE, ATTACK, SUSTAIN, RELEASE. Envelope register `env` is 8 bits.
  - IDLE: env = 0. If key_on = 1, go to ATTACK on the next edge. The level starts rising at the first following tick.
  - ATTACK: on tick, env = min(env+ATTACK_STEP, 255), computed with a 9-bit sum and saturation. When the new env = 255, go to SUSTAIN. If key_on = 0, go to RELEASE on the next edge, keeping the current env. key_on low takes priority over a tick in the same cycle: env is not incremented.
  - SUSTAIN: env held at 255. If key_on = 0, go to RELEASE.
  - RELEASE: on tick, env = max(env−RELEASE_STEP, 0). When the new env = 0, go to IDLE. If key_on = 1, go to ATTACK, retriggering from the current env (no jump to 0). key_on high takes priority over a tick.
- Scaling: c = sample_in − 128 as signed 9-bit; p = c × env as signed 18-bit, with env zero-extended. s = p >>> 8 (arithmetic shift, floors toward −∞). result = s + 128, truncated to 8 bits. The range is provably 0..254, so no overflow. Examples: sample 255 at env 255 gives 254; sample 0 at env 255 gives 0; any sample at env 0 gives 128.
- PWM: 8-bit counter `pcnt` increments every clock and wraps 255→0.
  - When pcnt = 255, `duty` latches the current scaled result, and level_out updates to that value in the same cycle.
  - pwm_out is registered: pwm_out = (pcnt < duty). duty 0 gives a constant low; duty 128 gives 128 of 256 cycles high.
- `env_out` = env. `active` = (state != IDLE), both registered.

## Timing
- Reset, when rst is sampled high: state = IDLE, env = 0, prescaler = 0, pcnt = 0, duty = 128, level_out = 128, pwm_out = 0, env_out = 0, active = 0.
- Reset mid-note drops the output to midscale immediately, with no release ramp.
- After rst deasserts, the first PWM period begins with pcnt = 0.
- The scaling path is combinational from the sample_in and env registers into the duty latch. The worst-case path is an 8×9 multiplier and fits within one clk period.
- Latency from a sample_in change to its effect on level_out: up to 256 clocks, at the next pcnt = 255. The effect reaches pwm_out 1 clock after the period starts.
- Latency from a key_on edge to the state change: 1 clock. From key_on rising in IDLE to the first env increase: ≤ ENV_DIV + 1 clocks.
- Full attack from 0 takes ceil(255/ATTACK_STEP) ticks; full release from 255 takes ceil(255/RELEASE_STEP) ticks.
- sample_in may change on any cycle; only the value present at pcnt = 255 matters. No handshake is used.

## Test plan
- Reset with sample_in = 200 and key_on = 0, then run 1000 clocks → level_out = 128, env_out = 0, active = 0, and pwm_out high for exactly 128 of every 256 clocks.
- ENV_DIV = 4, ATTACK_STEP = 64, key_on raised and held → env steps 64, 128, 192, 255 on successive ticks, then the FSM enters SUSTAIN. With sample_in = 255, level_out becomes 254 at the next period boundary and pwm_out is high for 254 of 256 cycles.
- From SUSTAIN with RELEASE_STEP = 100, key_on dropped → env goes 155, 55, 0, then IDLE with active = 0. Constant sample_in = 0 yields level_out 128 at env 0 and never goes below 0.
- Retrigger: ENV_DIV = 4, env = 155 in RELEASE, key_on raised → ATTACK from 155, next tick env = 155 + ATTACK_STEP, with no dip to 0.
- Same-cycle tick and key_on fall during ATTACK → env is unchanged that cycle and the state is RELEASE on the next clock.
- rst asserted for 1 cycle while in SUSTAIN with pcnt = 100 → next cycle all outputs are at their reset values and pcnt restarts at 0.
